// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// The controller FSM encoding is fixed so that traces and firmware debug dumps stay readable.
package fetch_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int BUS_WID_DEF = 64;
  localparam int MAX_OUT_DEF = 2;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_RUN  = 2'd1,
    FC_HALT = 2'd2
  } fc_state_e;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory line read bus: request/grant forward path, in-order response path.
interface fetch_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int BUS_WID = 64
) ();

    logic               req;
    logic [XLEN-1:0]    addr;
    logic               gnt;
    logic               rvld;
    logic [BUS_WID-1:0] rdata;
    logic               rerr;

    modport master (
        output req, addr,
        input  gnt, rvld, rdata, rerr
    );

    modport slave (
        input  req, addr,
        output gnt, rvld, rdata, rerr
    );

endinterface

// File: rtl/fetch_ctrl_fc_credit.sv
// Outstanding-request and stale-response bookkeeping for the fetch controller.
// out_cnt counts granted-but-unanswered reads; drop_cnt counts how many of those are stale.
module fc_credit
    import fetch_ctrl_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic grant,
    input  logic resp,
    input  logic flush,
    output logic full,
    output logic drop,
    output logic empty
);

    localparam int CW = cnt_width(MAX_OUT);

    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] out_nxt;
    logic          resp_ok;

    // A response with nothing outstanding is a bus protocol violation and is ignored.
    assign resp_ok = resp & (out_cnt != '0);

    always_comb begin
        out_nxt = out_cnt;
        if (grant && !resp_ok)
            out_nxt = out_cnt + 1'b1;
        else if (!grant && resp_ok)
            out_nxt = out_cnt - 1'b1;
    end

    // NOTE: counters are state, so they update with <= and clear on the synchronous reset;
    // nothing else in this block needs a reset value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_nxt;
            if (flush)
                drop_cnt <= out_nxt;
            else if (resp_ok && (drop_cnt != '0))
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    assign full  = (out_cnt >= CW'(MAX_OUT));
    assign drop  = (drop_cnt != '0);
    assign empty = (out_cnt == '0);

    a_resp_outstanding : assert property (@(posedge clk) disable iff (!rst)
        resp |-> (out_cnt != '0));

    a_drop_le_out : assert property (@(posedge clk) disable iff (!rst)
        drop_cnt <= out_cnt);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues sequential line reads from the last jump target,
// throttled by bit-buffer room and an outstanding limit, and filters stale responses.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int BUS_WID = BUS_WID_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_vld,
    input  logic [XLEN-1:0]    jump_pc,
    input  logic               buffer_free,
    fetch_ctrl_if.master       imem,
    output logic               line_vld,
    output logic [BUS_WID-1:0] line_data,
    output logic               line_err
);

    localparam int              BUS_BYTES  = BUS_WID / 8;
    localparam logic [XLEN-1:0] LINE_STEP  = XLEN'(BUS_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(BUS_BYTES - 1);

    fc_state_e       state;
    logic [XLEN-1:0] fetch_addr;
    logic            grant;
    logic            full;
    logic            drop;
    logic            empty;

    // NOTE: request and line forwarding are combinational so a jump suppresses them in the
    // same cycle and a live response reaches the bit buffer with zero latency.
    assign imem.req  = (state == FC_RUN) & buffer_free & ~full & ~jump_vld;
    assign imem.addr = fetch_addr;
    assign grant     = imem.req & imem.gnt;

    assign line_vld  = imem.rvld & ~empty & ~drop & ~jump_vld;
    assign line_data = imem.rdata;
    assign line_err  = imem.rerr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FC_IDLE;
            fetch_addr <= '0;
        end else if (jump_vld) begin
            state      <= FC_RUN;
            fetch_addr <= jump_pc & ALIGN_MASK;
        end else begin
            if (grant)
                fetch_addr <= fetch_addr + LINE_STEP;
            // The erroring line itself is still forwarded; only further issue stops.
            if ((state == FC_RUN) && line_vld && imem.rerr)
                state <= FC_HALT;
        end
    end

    fc_credit #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .grant (grant),
        .resp  (imem.rvld),
        .flush (jump_vld),
        .full  (full),
        .drop  (drop),
        .empty (empty)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queue-based reference model checked every cycle.
module tb_fetch_ctrl;

    localparam int XLEN      = 32;
    localparam int BUS_WID   = 64;
    localparam int MAX_OUT   = 2;
    localparam int BUS_BYTES = BUS_WID / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               jump_vld;
    logic [XLEN-1:0]    jump_pc;
    logic               buffer_free;
    logic               line_vld;
    logic [BUS_WID-1:0] line_data;
    logic               line_err;

    fetch_ctrl_if #(.XLEN(XLEN), .BUS_WID(BUS_WID)) imem ();

    fetch_ctrl #(
        .XLEN    (XLEN),
        .BUS_WID (BUS_WID),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_vld    (jump_vld),
        .jump_pc     (jump_pc),
        .buffer_free (buffer_free),
        .imem        (imem),
        .line_vld    (line_vld),
        .line_data   (line_data),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int data_seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of in-flight reads, each flagged live or stale.
    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_e;
    mstate_e         m_st = M_IDLE;
    bit              m_live[$];
    logic [XLEN-1:0] m_pc = '0;

    always @(negedge clk) begin
        bit e_req;
        bit e_fwd;
        if (cmp_en) begin
            e_req = (m_st == M_RUN) && buffer_free && (m_live.size() < MAX_OUT) && !jump_vld;
            e_fwd = imem.rvld && (m_live.size() > 0) && m_live[0] && !jump_vld;
            check("m_req", imem.req, e_req);
            check("m_addr", imem.addr, m_pc);
            check("m_line_vld", line_vld, e_fwd);
            if (e_fwd) begin
                check("m_line_data", line_data, imem.rdata);
                check("m_line_err", line_err, imem.rerr);
            end
            if (!rst) begin
                m_st = M_IDLE;
                m_live.delete();
                m_pc = '0;
            end else begin
                if (imem.rvld && (m_live.size() > 0))
                    void'(m_live.pop_front());
                if (jump_vld) begin
                    foreach (m_live[i]) m_live[i] = 1'b0;
                    m_st = M_RUN;
                    m_pc = jump_pc & ~32'(BUS_BYTES - 1);
                end else begin
                    if (e_req && imem.gnt) begin
                        m_live.push_back(1'b1);
                        m_pc = m_pc + 32'(BUS_BYTES);
                    end
                    if (e_fwd && imem.rerr && (m_st == M_RUN))
                        m_st = M_HALT;
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set(input bit j, input logic [XLEN-1:0] pc, input bit fr,
                       input bit g, input bit rv, input bit er);
        jump_vld    = j;
        jump_pc     = pc;
        buffer_free = fr;
        imem.gnt    = g;
        imem.rvld   = rv;
        imem.rerr   = er;
        data_seq++;
        imem.rdata  = {32'hC0DE_0000, 32'(data_seq)};
        #1;
    endtask

    initial begin
        rst = 1'b0;
        set(0, '0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        cyc();
        check("rst_req", imem.req, 0);
        check("rst_addr", imem.addr, 0);
        check("rst_line_vld", line_vld, 0);
        rst = 1'b1;

        // 1: sequential issue from an unaligned jump target, capped at two outstanding
        set(1, 32'h1006, 1, 1, 0, 0);
        check("t1_jump_req", imem.req, 0);
        cyc();
        set(0, '0, 1, 1, 0, 0);
        check("t1_req0", imem.req, 1);
        check("t1_addr0", imem.addr, 32'h1000);
        cyc();
        check("t1_addr1", imem.addr, 32'h1008);
        cyc();
        check("t1_full_req", imem.req, 0);
        check("t1_full_addr", imem.addr, 32'h1010);
        set(0, '0, 1, 1, 1, 0);
        check("t1_rsp_vld", line_vld, 1);
        check("t1_rsp_data", line_data, {32'hC0DE_0000, 32'(data_seq)});
        cyc();
        set(0, '0, 1, 1, 0, 0);
        check("t1_resume_req", imem.req, 1);
        check("t1_resume_addr", imem.addr, 32'h1010);
        cyc();

        // 2: jump with two in flight; both responses are stale
        set(1, 32'h2000, 1, 1, 0, 0);
        check("t2_jump_req", imem.req, 0);
        cyc();
        set(0, '0, 1, 0, 1, 0);
        check("t2_stale0", line_vld, 0);
        cyc();
        set(0, '0, 1, 0, 1, 0);
        check("t2_stale1", line_vld, 0);
        check("t2_addr", imem.addr, 32'h2000);
        cyc();
        set(0, '0, 1, 1, 0, 0);
        check("t2_req", imem.req, 1);
        check("t2_req_addr", imem.addr, 32'h2000);
        cyc();
        set(0, '0, 1, 0, 1, 0);
        check("t2_live", line_vld, 1);
        cyc();

        // 3: jump coincides with a response and a (suppressed) grant; one stale left
        set(0, '0, 1, 1, 0, 0);
        check("t3_addr", imem.addr, 32'h2008);
        cyc(2);
        check("t3_full_req", imem.req, 0);
        set(1, 32'h200e, 1, 1, 1, 0);
        check("t3_jump_rsp", line_vld, 0);
        check("t3_jump_req", imem.req, 0);
        cyc();
        set(0, '0, 1, 0, 1, 0);
        check("t3_stale", line_vld, 0);
        cyc();
        set(0, '0, 1, 1, 0, 0);
        check("t3_req_addr", imem.addr, 32'h2008);
        cyc();
        set(0, '0, 1, 0, 1, 0);
        check("t3_live", line_vld, 1);
        cyc();

        // 4: buffer full for five cycles holds the address
        set(0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_req", imem.req, 0);
            check("t4_hold_addr", imem.addr, 32'h2010);
            cyc();
        end
        set(0, '0, 1, 1, 0, 0);
        check("t4_resume_req", imem.req, 1);
        check("t4_resume_addr", imem.addr, 32'h2010);
        cyc();

        // 5: live bus error forwards the line and halts issue until the next jump
        set(0, '0, 1, 0, 1, 1);
        check("t5_err_vld", line_vld, 1);
        check("t5_err", line_err, 1);
        cyc();
        set(0, '0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("t5_halt_req", imem.req, 0);
            cyc();
        end
        set(1, 32'h3000, 1, 1, 0, 0);
        cyc();
        set(0, '0, 1, 1, 0, 0);
        check("t5_rejump_req", imem.req, 1);
        check("t5_rejump_addr", imem.addr, 32'h3000);
        cyc();
        check("t5_next_addr", imem.addr, 32'h3008);
        cyc();

        // 6: reset with two outstanding; late responses are ignored
        check("t6_full_req", imem.req, 0);
        rst = 1'b0;
        set(0, '0, 1, 0, 0, 0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            set(0, '0, 1, 0, 1, 0);
            check("t6_late_rsp", line_vld, 0);
            cyc();
        end
        rst = 1'b1;
        set(0, '0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("t6_idle_req", imem.req, 0);
            check("t6_idle_addr", imem.addr, 0);
            cyc();
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
